pipe_skid_stage: RTL
====================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width in bits (legal 1..256).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the stall counter width (legal 1..32).
REQ-003 The block SHALL have port CLK, input, 1 bit, the single rising-edge clock.
REQ-004 The block SHALL have port RST, input, 1 bit, reset: asynchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the upstream stage offers in_data.
REQ-006 The block SHALL have port in_data, input, DATA_W bits, the upstream payload.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the stage accepts in_data this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning out_data holds a live word.
REQ-009 The block SHALL have port out_data, output, DATA_W bits, the downstream payload.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning the downstream stage accepts out_data.
REQ-011 The block SHALL have port flush, input, 1 bit, a synchronous squash of all held words (branch/jump mispredict).
REQ-012 The block SHALL have port clr_stats, input, 1 bit, a synchronous clear of stall_count.
REQ-013 The block SHALL have port occupancy, output, 2 bits, the number of held words (0..2).
REQ-014 The block SHALL have port stall_count, output, CNT_W bits, the count of downstream-stall cycles.

Function
REQ-015 An input transfer SHALL occur on a CLK edge where in_valid=1 and in_ready=1; an output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-016 The stage SHALL hold a main register (drives out_data) and one skid register, with states EMPTY (occ 0), ONE (occ 1) and TWO (occ 2).
REQ-017 In EMPTY, an input transfer SHALL load main and go to ONE; otherwise the stage SHALL stay in EMPTY.
REQ-018 In ONE, input and output transfers together SHALL load main from in_data and stay in ONE.
REQ-019 In ONE, an input transfer without an output transfer SHALL load skid and go to TWO.
REQ-020 In ONE, an output transfer without an input transfer SHALL go to EMPTY.
REQ-021 In TWO, an output transfer SHALL copy skid to main and go to ONE; no input transfer is possible in TWO.
REQ-022 out_valid SHALL be 1 exactly when the state is not EMPTY; out_data SHALL be the main register.
REQ-023 in_ready SHALL be a flop output equal to "next state is not TWO", with no combinational path from out_ready.
REQ-024 Latency SHALL be 1 cycle: a word accepted at edge N appears on out_data after edge N when the stage was EMPTY, or was ONE with an output transfer at N.
REQ-025 Words SHALL leave in acceptance order, with no loss or duplication, under any valid/ready pattern.
REQ-026 flush=1 at an edge SHALL force state EMPTY and in_ready=1 after that edge.
REQ-027 flush SHALL override every transition, and any input word offered in the flush cycle SHALL be discarded.
REQ-028 An output handshake in the flush cycle SHALL still count as completed downstream.
REQ-029 stall_count SHALL increment by 1 at each edge where out_valid=1 and out_ready=0, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-030 clr_stats=1 SHALL zero stall_count at that edge and take priority over an increment in the same cycle; flush SHALL NOT affect stall_count.
REQ-031 Held-word payload SHALL NOT change while out_valid=1 and out_ready=0, so out_data is stable under stall.

Reset
REQ-032 While RST=1, state SHALL be EMPTY and main, skid and stall_count SHALL be 0.
REQ-033 While RST=1, out_valid SHALL be 0, occupancy 0 and in_ready 0, taking effect immediately without waiting for a CLK edge.
REQ-034 in_ready SHALL become 1 at the first CLK rising edge after RST deasserts.
REQ-035 RST asserted mid-transfer SHALL discard all held words, and no word offered during reset SHALL be accepted.

Verification
REQ-036 Reset release, then in_valid=1 with data 0x11, 0x22, 0x33 on consecutive cycles and out_ready=1 -> out_data 0x11, 0x22, 0x33 one cycle later each; occupancy stays 1; stall_count stays 0.
REQ-037 Stage in ONE holding 0xA, out_ready=0, 0xB offered -> occupancy 2 and in_ready=0.
REQ-038 Continuing REQ-037, out_ready=1 for two cycles -> 0xA then 0xB delivered and state EMPTY; stall_count equals the stalled-cycle count.
REQ-039 Stage in TWO, flush=1 together with in_valid=1 and data 0xC -> next cycle occupancy 0, out_valid 0, in_ready 1, and 0xC is never output.
REQ-040 CNT_W=2, out_ready held 0 for 6 cycles with out_valid=1 -> stall_count reads 3 (saturated).
REQ-041 Continuing REQ-040, clr_stats=1 in the same cycle as a stall -> stall_count 0.
REQ-042 RST asserted asynchronously mid-cycle while in TWO -> out_valid, occupancy and in_ready are 0 before the next edge; after release in_ready=1 at the first edge.
REQ-043 Random valid/ready (50% each), 10,000 words -> scoreboard shows in-order, lossless delivery and in_ready never 1 in TWO.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: one-deep pipeline register with a single skid slot.
// The main register drives the output. The skid slot catches the one word
// that can arrive while the downstream stage stalls. in_ready is registered,
// so out_ready never reaches in_ready through combinational logic. A
// saturating counter records the cycles in which the downstream stage stalls.
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              clr_stats,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   r_skid;
  logic                r_in_ready;
  logic [CNT_W-1:0]    r_stall;

  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_ld_main_in;
  logic                w_ld_main_skid;
  logic                w_ld_skid;
  logic                w_stall_cycle;
  logic                w_stall_sat;

  assign out_valid   = (r_state != ST_EMPTY);
  assign out_data    = r_main;
  assign in_ready    = r_in_ready;
  assign occupancy   = r_state;
  assign stall_count = r_stall;

  assign w_in_xfer     = in_valid & r_in_ready;
  assign w_out_xfer    = out_valid & out_ready;
  assign w_stall_cycle = out_valid & ~out_ready;
  assign w_stall_sat   = (r_stall == {CNT_W{1'b1}});

  // Next-state and register-load selection; flush overrides every transition.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_ld_main_in = 1'b1;
            w_state_nxt  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_ld_main_in = 1'b1;
          end else if (w_in_xfer) begin
            w_ld_skid   = 1'b1;
            w_state_nxt = ST_TWO;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is 0 here, so the only possible event is the downstream draining main.
          if (w_out_xfer) begin
            w_ld_main_skid = 1'b1;
            w_state_nxt    = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State and registered in_ready; in_ready tracks "next state is not TWO".
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  // Payload registers; they change only when a word moves, so out_data holds during a stall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the payload registers are cleared on reset so out_data reads 0 until a word arrives.
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main <= in_data;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= in_data;
      end
    end
  end

  // Stall counter: saturating increment, clr_stats has priority, flush leaves it alone.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall <= '0;
    end else if (clr_stats) begin
      r_stall <= '0;
    end else if (w_stall_cycle && !w_stall_sat) begin
      r_stall <= r_stall + 1'b1;
    end
  end

endmodule
